// File: rtl/branch_pkg.sv
// Shared branch-tracking definitions used by the update queue and the tournament predictor.
package branch_pkg;

  localparam int BQ_DEPTH    = 8;
  localparam int BQ_PC_WIDTH = 16;

  // Bit positions inside a stored entry. These offsets do not depend on the PC width,
  // so any PC_WIDTH packs the same way as branch_entry_t.
  localparam int PRED_BIT        = 0;
  localparam int P_BIT           = 1;
  localparam int G_BIT           = 2;
  localparam int PC_LSB          = 3;
  localparam int ENTRY_META_BITS = 3;

  typedef struct packed {
    logic [BQ_PC_WIDTH-1:0] pc;
    logic                   g;
    logic                   p;
    logic                   pred;
  } branch_entry_t;

endpackage

// File: rtl/branch_entry_ram.sv
// Entry storage: one synchronous write port and one asynchronous read port.
module branch_entry_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wAddr,
  input  logic [WIDTH-1:0]         wData,
  input  logic [$clog2(DEPTH)-1:0] rAddr,
  output logic [WIDTH-1:0]         rData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches; on resolve it pops the oldest entry and
// emits a one-cycle predictor training strobe, flushing younger entries on a mispredict.
module branch_update_queue
  import branch_pkg::*;
#(
  parameter int DEPTH    = BQ_DEPTH,
  parameter int PC_WIDTH = BQ_PC_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc,
  input  logic [PC_WIDTH-1:0]        allocPC,
  input  logic                       allocG,
  input  logic                       allocP,
  input  logic                       allocPred,
  input  logic                       resolve,
  input  logic                       resolveTaken,
  output logic                       update,
  output logic [PC_WIDTH-1:0]        updatePC,
  output logic                       gReality,
  output logic                       pReality,
  output logic                       reality,
  output logic                       mispredict,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       error
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = PC_WIDTH + ENTRY_META_BITS;

  logic [PTR_W-1:0]   head, tail;
  logic [ENTRY_W-1:0] headEntry, newEntry;
  logic               allocOk, resolveOk, flush, headPred;

  // Handshake: alloc and resolve are single-cycle requests with no back-pressure.
  // A request is accepted when full/empty (from registered count) allow it; a
  // rejected request is dropped and latched into the sticky error flag, except an
  // alloc that coincides with a mispredict flush, which is dropped silently.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign headPred  = headEntry[PRED_BIT];
  assign resolveOk = resolve && !empty;
  assign flush     = resolveOk && (headPred != resolveTaken);
  assign allocOk   = alloc && !full && !flush;
  assign newEntry  = {allocPC, allocG, allocP, allocPred};

  branch_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (allocOk && !reset),
    .wAddr (tail),
    .wData (newEntry),
    .rAddr (head),
    .rData (headEntry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      error      <= 1'b0;
      update     <= 1'b0;
      updatePC   <= '0;
      gReality   <= 1'b0;
      pReality   <= 1'b0;
      reality    <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      if ((alloc && full && !flush) || (resolve && empty)) error <= 1'b1;

      if (flush) begin
        // Everything younger than the mispredicted branch is wrong-path work.
        head  <= head + PTR_W'(1);
        tail  <= head + PTR_W'(1);
        count <= '0;
      end else begin
        if (allocOk)   tail <= tail + PTR_W'(1);
        if (resolveOk) head <= head + PTR_W'(1);
        case ({allocOk, resolveOk})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      update <= resolveOk;
      if (resolveOk) begin
        updatePC   <= headEntry[PC_LSB +: PC_WIDTH];
        gReality   <= (headEntry[G_BIT] == resolveTaken);
        pReality   <= (headEntry[P_BIT] == resolveTaken);
        reality    <= resolveTaken;
        mispredict <= (headPred != resolveTaken);
      end
    end
  end

endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning in-flight branch entries (power of two, 2..64).
REQ-002 SHALL have parameter PC_WIDTH, default 16, meaning branch PC width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port alloc, input, 1 bit: fetch issued a predicted branch this cycle.
REQ-007 SHALL have port allocPC, input, PC_WIDTH bits: PC of the allocated branch.
REQ-008 SHALL have ports allocG, allocP and allocPred, input, 1 bit each: global, local and final tournament prediction.
REQ-009 SHALL have port resolve, input, 1 bit: the oldest outstanding branch resolved this cycle.
REQ-010 SHALL have port resolveTaken, input, 1 bit: actual outcome of that branch.
REQ-011 SHALL have port update, output, 1 bit: predictor update strobe.
REQ-012 SHALL have port updatePC, output, PC_WIDTH bits: PC of the branch being trained.
REQ-013 SHALL have ports gReality, pReality and reality, output, 1 bit each: global-correct, local-correct and actual outcome.
REQ-014 SHALL have port mispredict, output, 1 bit: final prediction was wrong and the pipeline must redirect.
REQ-015 SHALL have ports full and empty, output, 1 bit each, plus count, output, log2(DEPTH)+1 bits.
REQ-016 SHALL have port error, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-017 SHALL store entries {PC, G, P, Pred} in a circular FIFO with head/tail pointers that wrap modulo DEPTH.
REQ-018 SHALL combinationally drive full = (count==DEPTH) and empty = (count==0) from registered count.
REQ-019 SHALL write alloc at tail when not full; alloc while full is dropped and sets error.
REQ-020 SHALL pop the head entry on resolve when not empty; resolve while empty is ignored and sets error.
REQ-021 SHALL register update, updatePC, gReality, pReality, reality and mispredict one cycle after an accepted resolve; update is high for exactly that cycle, otherwise low, and the data outputs hold their last values.
REQ-022 SHALL compute gReality = (G==resolveTaken), pReality = (P==resolveTaken), reality = resolveTaken and mispredict = (Pred!=resolveTaken).
REQ-023 SHALL flush on a mispredicting resolve: all younger entries are discarded, tail = head+1, count = 0, and a same-cycle alloc is dropped without setting error.
REQ-024 SHALL accept both operations on a non-mispredicting alloc+resolve in the same cycle: count unchanged and both pointers advance; if full, the alloc is still dropped because full is taken from registered count.
REQ-025 SHALL ignore allocPC/allocG/allocP/allocPred when alloc=0 and ignore resolveTaken when resolve=0.

Reset
REQ-026 SHALL, when reset=1 at a rising edge, set head=tail=0, count=0, update=0, mispredict=0, error=0, updatePC=0 and gReality=pReality=reality=0, so empty=1 and full=0.
REQ-027 SHALL give reset priority over alloc and resolve in the same cycle, discarding all in-flight entries; entry storage need not be cleared.

Structure
REQ-028 SHALL take DEPTH and PC_WIDTH defaults and the entry record type (PC, G, P, Pred) from shared package branch_pkg, which TournamentPredictor also uses.
REQ-029 SHALL hold entries in one sub-module, branch_entry_ram, with one write port and one asynchronous read port, DEPTH x (PC_WIDTH+3) bits.

Verification
REQ-030 SHALL cover basic pass-through: alloc PC=0x00AA with G=0, P=1, Pred=1, then resolve taken=1; the next cycle gives update=1, updatePC=0x00AA, gReality=0, pReality=1, reality=1, mispredict=0 and empty=1.
REQ-031 SHALL cover the mispredict flush: alloc 0x0010 (Pred=0), 0x0020 and 0x0030, then resolve taken=1 with a same-cycle alloc 0x0040; the next cycle gives mispredict=1, updatePC=0x0010, count=0 and error=0.
REQ-032 SHALL cover full/overflow: 8 allocs give full=1 and count=8; a ninth alloc leaves count=8 and sets error=1, and 8 correct resolves return PCs in alloc order.
REQ-033 SHALL cover wrap-around: 6 allocs, 6 resolves, then 5 allocs and 5 resolves all return their PCs in order with no error.
REQ-034 SHALL cover underflow plus simultaneous events: resolve when empty gives update=0 and error=1; with count=3, a correct alloc+resolve gives count=3 and FIFO order preserved.
REQ-035 SHALL cover reset mid-operation: with count=4, asserting reset with alloc=1 gives count=0, empty=1, update=0 and error=0 the next cycle.
